dbg_ram_port_arbiter: RTL and testbench

//  Shares the second (debug) port of InstRAM and DataRAM between two requesters.
//  m0 is the host debugger and m1 is the boot/DMA loader.

---
 rtl/dbg_arb_pkg.sv | 13 +
 rtl/dbg_rr_arb2.sv | 21 ++
 rtl/dbg_ram_port_arbiter.sv | 128 ++++++++++++
 tb/tb_dbg_ram_port_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_arb_pkg.sv
// rtl/dbg_arb_pkg.sv - shared encodings for the debug RAM port arbiter
package dbg_arb_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic TGT_DRAM = 1'b0;
  localparam logic TGT_IRAM = 1'b1;
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;
endpackage

// File: rtl/dbg_rr_arb2.sv
// rtl/dbg_rr_arb2.sv - two-way round-robin grant; pointer moves to the non-winner
module dbg_rr_arb2
  import dbg_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       rr_ptr,
  input  logic       enable,
  output logic [1:0] grant,
  output logic       next_ptr
);
  always_comb begin
    grant    = 2'b00;
    next_ptr = rr_ptr;
    if (enable) begin
      if (valid == 2'b11) grant[rr_ptr] = 1'b1;
      else                grant = valid;
      if (grant[1])      next_ptr = M0;
      else if (grant[0]) next_ptr = M1;
    end
  end
endmodule

// File: rtl/dbg_ram_port_arbiter.sv
// rtl/dbg_ram_port_arbiter.sv - shares InstRAM/DataRAM debug ports between two masters
// Optional cpu_stall_req output under macro DBG_ARB_CPU_STALL_EN.
module dbg_ram_port_arbiter
  import dbg_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                m0_req_valid,
  output logic                m0_req_ready,
  input  logic                m0_req_tgt,
  input  logic [ADDR_W-1:0]   m0_req_addr,
  input  logic [DATA_W-1:0]   m0_req_wdata,
  input  logic [DATA_W/8-1:0] m0_req_we,
  output logic                m0_rsp_valid,
  output logic [DATA_W-1:0]   m0_rsp_rdata,
  input  logic                m1_req_valid,
  output logic                m1_req_ready,
  input  logic                m1_req_tgt,
  input  logic [ADDR_W-1:0]   m1_req_addr,
  input  logic [DATA_W-1:0]   m1_req_wdata,
  input  logic [DATA_W/8-1:0] m1_req_we,
  output logic                m1_rsp_valid,
  output logic [DATA_W-1:0]   m1_rsp_rdata,
  output logic [ADDR_W-1:0]   dram_a2,
  output logic [DATA_W-1:0]   dram_wd2,
  output logic [DATA_W/8-1:0] dram_we2,
  input  logic [DATA_W-1:0]   dram_rd2,
  output logic [ADDR_W-1:0]   iram_a2,
  output logic [DATA_W-1:0]   iram_wd2,
  output logic [DATA_W/8-1:0] iram_we2,
  input  logic [DATA_W-1:0]   iram_rd2
`ifdef DBG_ARB_CPU_STALL_EN
  ,
  output logic                cpu_stall_req
`endif
);
  state_t              state;
  logic                rr_ptr;
  logic [1:0]          grant;
  logic                next_ptr;
  logic                hs;
  logic                sel_tgt;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [DATA_W/8-1:0] sel_we;
  logic                cap_tgt;
  logic                cap_mid;
  logic                cap_read;
  logic [DATA_W-1:0]   rsp_data;

  dbg_rr_arb2 u_arb (
    .valid    ({m1_req_valid, m0_req_valid}),
    .rr_ptr   (rr_ptr),
    .enable   (state == IDLE || state == RESP),
    .grant    (grant),
    .next_ptr (next_ptr)
  );

  assign m0_req_ready = grant[0];
  assign m1_req_ready = grant[1];
  assign hs           = |grant;
  assign sel_tgt      = grant[1] ? m1_req_tgt   : m0_req_tgt;
  assign sel_addr     = grant[1] ? m1_req_addr  : m0_req_addr;
  assign sel_wdata    = grant[1] ? m1_req_wdata : m0_req_wdata;
  assign sel_we       = grant[1] ? m1_req_we    : m0_req_we;

  // Port registers double as the captured address/data; we2 lives for the ISSUE cycle only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= M0;
      cap_tgt  <= TGT_DRAM;
      cap_mid  <= M0;
      cap_read <= 1'b0;
      dram_a2  <= '0;
      dram_wd2 <= '0;
      dram_we2 <= '0;
      iram_a2  <= '0;
      iram_wd2 <= '0;
      iram_we2 <= '0;
    end else begin
      dram_we2 <= '0;
      iram_we2 <= '0;
      case (state)
        IDLE:    state <= hs ? ISSUE : IDLE;
        ISSUE:   state <= RESP;
        RESP:    state <= hs ? ISSUE : IDLE;
        default: state <= IDLE;
      endcase
      if (hs) begin
        rr_ptr   <= next_ptr;
        cap_tgt  <= sel_tgt;
        cap_mid  <= grant[1];
        cap_read <= (sel_we == '0);
        if (sel_tgt == TGT_IRAM) begin
          iram_a2  <= sel_addr;
          iram_wd2 <= sel_wdata;
          iram_we2 <= sel_we;
        end else begin
          dram_a2  <= sel_addr;
          dram_wd2 <= sel_wdata;
          dram_we2 <= sel_we;
        end
      end
    end
  end

  // RAM read data arrives the cycle after the address, which is the RESP cycle.
  assign rsp_data     = !cap_read ? '0 : (cap_tgt == TGT_IRAM) ? iram_rd2 : dram_rd2;
  assign m0_rsp_valid = (state == RESP) && (cap_mid == M0);
  assign m1_rsp_valid = (state == RESP) && (cap_mid == M1);
  assign m0_rsp_rdata = m0_rsp_valid ? rsp_data : '0;
  assign m1_rsp_rdata = m1_rsp_valid ? rsp_data : '0;

`ifdef DBG_ARB_CPU_STALL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cpu_stall_req <= 1'b0;
    else if (hs && sel_tgt == TGT_IRAM && sel_we != '0)
      cpu_stall_req <= 1'b1;
    else if (state == IDLE)
      cpu_stall_req <= 1'b0;
  end
`endif
endmodule

// File: tb/tb_dbg_ram_port_arbiter.sv
// tb/tb_dbg_ram_port_arbiter.sv - self-checking bench for dbg_ram_port_arbiter
`timescale 1ns/1ps
module tb_dbg_ram_port_arbiter;
  typedef struct {
    logic        t;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  w;
    bit          drop;
  } req_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        vld [2];
  logic        tgt [2];
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [3:0]  we [2];
  logic        rdy [2];
  logic        rv [2];
  logic [31:0] rd [2];
  logic [31:0] dram_a2, dram_wd2, dram_rd2, iram_a2, iram_wd2, iram_rd2;
  logic [3:0]  dram_we2, iram_we2;
`ifdef DBG_ARB_CPU_STALL_EN
  logic        cpu_stall_req;
`endif

  dbg_ram_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_valid(vld[0]), .m0_req_ready(rdy[0]), .m0_req_tgt(tgt[0]),
    .m0_req_addr(addr[0]), .m0_req_wdata(wdata[0]), .m0_req_we(we[0]),
    .m0_rsp_valid(rv[0]), .m0_rsp_rdata(rd[0]),
    .m1_req_valid(vld[1]), .m1_req_ready(rdy[1]), .m1_req_tgt(tgt[1]),
    .m1_req_addr(addr[1]), .m1_req_wdata(wdata[1]), .m1_req_we(we[1]),
    .m1_rsp_valid(rv[1]), .m1_rsp_rdata(rd[1]),
    .dram_a2(dram_a2), .dram_wd2(dram_wd2), .dram_we2(dram_we2), .dram_rd2(dram_rd2),
    .iram_a2(iram_a2), .iram_wd2(iram_wd2), .iram_we2(iram_we2), .iram_rd2(iram_rd2)
`ifdef DBG_ARB_CPU_STALL_EN
    , .cpu_stall_req(cpu_stall_req)
`endif
  );

  int tests = 0;
  int fails = 0;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dfun(logic [31:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : ((a * 32'h9E3779B1) ^ 32'h5A5A5A5A);
  endfunction
  function automatic logic [31:0] ifun(logic [31:0] a);
    return (a * 32'h85EBCA6B) ^ 32'hC3C3C3C3;
  endfunction
  function automatic req_t mk(logic t, logic [31:0] a, logic [31:0] d, logic [3:0] w, bit drop);
    req_t r;
    r.t = t; r.a = a; r.d = d; r.w = w; r.drop = drop;
    return r;
  endfunction

  req_t q0[$], q1[$];
  bit   hs_seen [2];
  logic [31:0] prev_da = '0, prev_ia = '0;

  // Request drivers plus RAM models returning data one cycle after the address.
  initial begin
    for (int n = 0; n < 2; n++) begin
      vld[n] = 0; tgt[n] = 0; addr[n] = '0; wdata[n] = '0; we[n] = '0;
    end
    dram_rd2 = '0; iram_rd2 = '0;
    forever begin
      @(posedge clk); #1;
      dram_rd2 = dfun(prev_da); prev_da = dram_a2;
      iram_rd2 = ifun(prev_ia); prev_ia = iram_a2;
      if (q0.size() > 0 && (hs_seen[0] || (q0[0].drop && vld[0]))) void'(q0.pop_front());
      if (q1.size() > 0 && (hs_seen[1] || (q1[0].drop && vld[1]))) void'(q1.pop_front());
      vld[0] = (q0.size() > 0);
      if (vld[0]) begin tgt[0] = q0[0].t; addr[0] = q0[0].a; wdata[0] = q0[0].d; we[0] = q0[0].w; end
      vld[1] = (q1.size() > 0);
      if (vld[1]) begin tgt[1] = q1[0].t; addr[1] = q1[0].a; wdata[1] = q1[0].d; we[1] = q1[0].w; end
    end
  end

  // Transaction-level model: a grant is possible 2+ cycles after the previous one.
  int   cyc = 0;
  int   last_hs = -100;
  bit   fav = 0;
  bit   tx_ok = 0;
  int   tx_hs = 0;
  int   tx_mid = 0;
  req_t tx;
  bit   stall_m = 0;
  logic [31:0] ea2 [2];
  logic [31:0] ewd2 [2];
  int   iwe_cnt = 0;
  int   hs_cyc[$], hs_mid[$], rsp_cyc[$], rsp_mid[$];
  logic [31:0] rsp_dat[$];

  always @(negedge clk) begin : chk
    logic [3:0]  ewe [2];
    bit          erv [2];
    logic [31:0] erd [2];
    int          win;
    cyc++;
    if (!rst_n) begin
      last_hs = -100; fav = 0; tx_ok = 0; stall_m = 0;
      for (int n = 0; n < 2; n++) begin ea2[n] = '0; ewd2[n] = '0; hs_seen[n] = 0; end
      check("rst_dram_we2", dram_we2, 0);
      check("rst_iram_we2", iram_we2, 0);
      check("rst_m0_rsp_valid", rv[0], 0);
      check("rst_m1_rsp_valid", rv[1], 0);
      check("rst_dram_a2", dram_a2, 0);
      check("rst_iram_wd2", iram_wd2, 0);
`ifdef DBG_ARB_CPU_STALL_EN
      check("rst_stall", cpu_stall_req, 0);
`endif
    end else begin
      for (int n = 0; n < 2; n++) begin ewe[n] = '0; erv[n] = 0; erd[n] = '0; end
      if (tx_ok && cyc == tx_hs + 1) begin
        ea2[tx.t] = tx.a; ewd2[tx.t] = tx.d; ewe[tx.t] = tx.w;
      end
      if (tx_ok && cyc == tx_hs + 2) begin
        erv[tx_mid] = 1;
        if (tx.w == 0) erd[tx_mid] = tx.t ? ifun(tx.a) : dfun(tx.a);
      end
      win = -1;
      if (cyc - last_hs >= 2) begin
        if (vld[0] && vld[1]) win = fav;
        else if (vld[0])      win = 0;
        else if (vld[1])      win = 1;
      end
      for (int n = 0; n < 2; n++) begin
        check($sformatf("m%0d_req_ready", n), rdy[n], (win == n));
        check($sformatf("m%0d_rsp_valid", n), rv[n], erv[n]);
        check($sformatf("m%0d_rsp_rdata", n), rd[n], erd[n]);
      end
      check("dram_a2", dram_a2, ea2[0]);
      check("dram_wd2", dram_wd2, ewd2[0]);
      check("dram_we2", dram_we2, ewe[0]);
      check("iram_a2", iram_a2, ea2[1]);
      check("iram_wd2", iram_wd2, ewd2[1]);
      check("iram_we2", iram_we2, ewe[1]);
`ifdef DBG_ARB_CPU_STALL_EN
      check("cpu_stall_req", cpu_stall_req, stall_m);
`endif
      if (iram_we2 != 0) iwe_cnt++;
      for (int n = 0; n < 2; n++)
        if (rv[n]) begin rsp_cyc.push_back(cyc); rsp_mid.push_back(n); rsp_dat.push_back(rd[n]); end
      if (win >= 0 && tgt[win] && we[win] != 0) stall_m = 1;
      else if (cyc - last_hs >= 3)               stall_m = 0;
      if (win >= 0) begin
        last_hs = cyc; fav = (win == 0);
        tx = mk(tgt[win], addr[win], wdata[win], we[win], 0);
        tx_mid = win; tx_hs = cyc; tx_ok = 1;
        hs_cyc.push_back(cyc); hs_mid.push_back(win);
      end
      for (int n = 0; n < 2; n++) hs_seen[n] = vld[n] && rdy[n];
    end
  end

  task automatic wait_hs(int n);
    int k = 0;
    while (hs_cyc.size() < n && k < 60) begin @(negedge clk); #1; k++; end
    check("wait_hs_timeout", (hs_cyc.size() >= n), 1);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (!(q0.size() == 0 && q1.size() == 0 && cyc - last_hs >= 4) && k < 300) begin
      @(negedge clk); #1; k++;
    end
    check("wait_idle_timeout", (k < 300), 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #2 rst_n = 0;
    @(posedge clk); #2 rst_n = 1;
    @(negedge clk); #1;
  endtask

  initial begin
    int n, r, b;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1;
    @(negedge clk); #1;

    // single read of DataRAM 0x10
    n = hs_cyc.size();
    q0.push_back(mk(0, 32'h10, 32'h0, 4'h0, 0));
    wait_hs(n + 1);
    check("rd_winner", hs_mid[n], 0);
    @(negedge clk); #1;
    check("rd_dram_a2_t1", dram_a2, 32'h10);
    check("rd_no_rsp_t1", rv[0], 0);
    @(negedge clk); #1;
    check("rd_rsp_valid_t2", rv[0], 1);
    check("rd_rdata_t2", rd[0], 32'hDEADBEEF);
    wait_idle();

    // contention from reset
    do_reset();
    n = hs_cyc.size();
    q0.push_back(mk(0, 32'h100, 0, 0, 0)); q0.push_back(mk(1, 32'h104, 0, 0, 0));
    q1.push_back(mk(0, 32'h200, 0, 0, 0)); q1.push_back(mk(1, 32'h204, 0, 0, 0));
    wait_hs(n + 4);
    for (int i = 0; i < 4; i++) check($sformatf("cont_order_%0d", i), hs_mid[n + i], i % 2);
    for (int i = 1; i < 4; i++) check($sformatf("cont_gap_%0d", i), hs_cyc[n + i] - hs_cyc[n + i - 1], 2);
    wait_idle();

    // byte write to InstRAM from m1
    b = iwe_cnt; r = rsp_cyc.size();
    q1.push_back(mk(1, 32'h4, 32'h000000AA, 4'b0001, 0));
    wait_idle();
    check("bw_we_cycles", iwe_cnt - b, 1);
    check("bw_rsp_count", rsp_cyc.size() - r, 1);
    check("bw_rsp_master", rsp_mid[r], 1);
    check("bw_rsp_rdata", rsp_dat[r], 0);

    // three back-to-back reads from m0
    n = hs_cyc.size(); r = rsp_cyc.size();
    q0.push_back(mk(0, 32'h300, 0, 0, 0));
    q0.push_back(mk(1, 32'h304, 0, 0, 0));
    q0.push_back(mk(0, 32'h10, 0, 0, 0));
    wait_idle();
    check("b2b_hs_count", hs_cyc.size() - n, 3);
    check("b2b_rsp_count", rsp_cyc.size() - r, 3);
    for (int i = 1; i < 3; i++) check($sformatf("b2b_rsp_gap_%0d", i), rsp_cyc[r + i] - rsp_cyc[r + i - 1], 2);

    // valid dropped before ready is never granted
    n = hs_cyc.size();
    q1.push_back(mk(0, 32'h20, 32'hAA55AA55, 4'hF, 0));
    q1.push_back(mk(1, 32'h30, 0, 0, 1));
    wait_idle();
    check("drop_hs_count", hs_cyc.size() - n, 1);

    // reset in ISSUE drops the write and restores m0 priority
    n = hs_cyc.size(); r = rsp_cyc.size();
    q0.push_back(mk(0, 32'h40, 32'h1234, 4'hF, 0));
    wait_hs(n + 1);
    @(posedge clk); #2 rst_n = 0;
    #1;
    check("rst_mid_issue_we2", dram_we2, 0);
    check("rst_mid_issue_rsp", rv[0], 0);
    @(posedge clk); #2 rst_n = 1;
    @(negedge clk); #1;
    check("rst_dropped_rsp", rsp_cyc.size() - r, 0);
    n = hs_cyc.size();
    q0.push_back(mk(0, 32'h10, 0, 0, 0));
    q1.push_back(mk(0, 32'h44, 0, 0, 0));
    wait_hs(n + 1);
    check("rst_rr_ptr_m0", hs_mid[n], 0);
    wait_idle();

`ifdef DBG_ARB_CPU_STALL_EN
    n = hs_cyc.size();
    q1.push_back(mk(1, 32'h8, 32'hCAFEF00D, 4'hF, 0));
    wait_hs(n + 1);
    @(negedge clk); #1;
    check("stall_set", cpu_stall_req, 1);
    wait_idle();
    check("stall_clear", cpu_stall_req, 0);
`endif

    // mixed traffic from both masters
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) q0.push_back(mk(i[1], 32'h500 + i * 4, 32'h11 * i, (i > 2) ? 4'b0110 : 4'b0000, 0));
      else            q1.push_back(mk(i[2], 32'h600 + i * 4, 32'h22 * i, (i > 2) ? 4'b1000 : 4'b0000, 0));
    end
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
